fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the instruction fetch path of the CPU. Owns the program counter. Issues one word-read request at a time to instruction memory over a req/ack handshake. Presents each fetched word to instr_decode through a valid/ready handshake. Applies branch redirects from the execute stage and discards any wrong-path words.

Parameters:
WORD_SIZE, 16, width of instructions, addresses and PC (from parameters.vh)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  WORD_SIZE  fetch address; stable while mem_req=1
mem_ack  input  1  single-cycle pulse; mem_data valid in the same cycle
mem_data  input  WORD_SIZE  fetched word
instr  output  WORD_SIZE  held instruction to decoder
instr_pc  output  WORD_SIZE  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  downstream accepts instr this cycle
branch_taken  input  1  single-cycle redirect pulse
branch_target  input  WORD_SIZE  new PC when branch_taken=1

Behaviour:
- States: FETCH (request outstanding), HOLD (word held for decoder), DISCARD (wrong-path request outstanding).
- Reset values:
  - state=FETCH, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, discard flag=0.
  - Reset overrides every other input, including mem_ack and branch_taken in the same cycle.
  - Any in-flight request is abandoned; memory must tolerate this.
- First cycle after reset deasserts: mem_req=1, mem_addr=RESET_PC.
- mem_req=1 in FETCH and DISCARD; 0 in HOLD.
- mem_addr always equals pc, and is held constant while a request is pending.
- FETCH:
  - mem_ack=1, branch_taken=0: instr<=mem_data, instr_pc<=pc, pc<=pc+1 (wraps modulo 2^WORD_SIZE), instr_valid<=1, go HOLD.
  - mem_ack=1, branch_taken=1: drop data, pc<=branch_target, stay FETCH. Next cycle mem_addr=target.
  - mem_ack=0, branch_taken=1: latch pc_pending<=branch_target, go DISCARD.
  - Neither: stay FETCH.
- DISCARD:
  - Wait for mem_ack; its data is dropped.
  - On ack: pc<=pc_pending, go FETCH.
  - A further branch_taken while in DISCARD overwrites pc_pending; the newest target wins.
  - Branch and ack in the same cycle: pc<=branch_target directly.
- HOLD:
  - instr_valid=1; instr and instr_pc stable until accepted.
  - branch_taken=1 (regardless of instr_ready): instr_valid<=0, pc<=branch_target, go FETCH. The held word is wrong-path and is never counted as accepted.
  - instr_ready=1, branch_taken=0: word consumed, instr_valid<=0, go FETCH at the already-incremented pc.
  - instr_ready=0: stay HOLD, indefinitely.
- Latency and throughput:
  - Zero-wait memory (ack in the first request cycle): word valid 1 cycle after ack.
  - Steady state: one instruction per 2 cycles with instr_ready tied high.
- mem_ack outside FETCH/DISCARD is ignored.

Test Plan:
- Reset then run, mem acks every request cycle, instr_ready=1, mem_data=addr+0x1000:
  - mem_addr sequence 0,1,2,3.
  - instr 0x1000,0x1001,... with matching instr_pc.
  - instr_valid high every other cycle.
- Backpressure: instr_ready=0 for 5 cycles while HOLD at addr 2:
  - instr=0x1002 stays stable; mem_req=0 throughout.
  - On ready, next mem_addr=3.
- Branch during pending fetch: memory delays ack 3 cycles at addr 4; branch_taken to 0x0040 on the 1st wait cycle:
  - Word for addr 4 is never presented.
  - Next request mem_addr=0x0040; instr_pc=0x0040 on the next valid.
- Branch in HOLD with instr_ready=1 same cycle, target 0x0100:
  - Held word dropped; instr_valid=0 next cycle; mem_addr=0x0100.
- Two branches in DISCARD, targets 0x0200 then 0x0300, then ack:
  - Fetch resumes at 0x0300.
- PC wrap: RESET_PC=0xFFFF:
  - First instr_pc=0xFFFF; next mem_addr=0x0000.
- Reset asserted mid-DISCARD with mem_ack the same cycle:
  - Next cycle instr_valid=0, mem_req=0, mem_addr=RESET_PC.
  - After reset drops: mem_req=1, mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches one word at a time from instruction memory and hands it to decode.
// Ports: clk/reset (sync, active-high); mem_req/mem_addr/mem_ack/mem_data = instruction memory
// req/ack handshake; instr/instr_pc/instr_valid/instr_ready = valid/ready link to decode;
// branch_taken/branch_target = redirect pulse from execute.
module fetch_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t state;
    logic [WORD_SIZE-1:0] pc, pc_pending;
    assign mem_addr = pc;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pc_pending  <= RESET_PC;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                // mem_req is low only in the first cycle out of reset: no request is
                // outstanding then, so a redirect needs no discard and an ack is ignored
                FETCH: begin
                    mem_req <= 1'b1;
                    if (branch_taken && mem_req && !mem_ack) begin
                        pc_pending <= branch_target;
                        state      <= DISCARD;
                    end else if (branch_taken) begin
                        pc <= branch_target;
                    end else if (mem_req && mem_ack) begin
                        instr       <= mem_data;
                        instr_pc    <= pc;
                        pc          <= pc + 1'b1;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= HOLD;
                    end
                end
                // pc stays put so mem_addr is stable until the wrong-path ack arrives
                DISCARD: begin
                    if (mem_ack) begin
                        pc    <= branch_taken ? branch_target : pc_pending;
                        state <= FETCH;
                    end else if (branch_taken) begin
                        pc_pending <= branch_target;
                    end
                end
                HOLD: begin
                    if (branch_taken || instr_ready) begin
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= FETCH;
                        if (branch_taken) pc <= branch_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus a PC-wrap sequence on a second instance.
module tb_fetch_sequencer;
    localparam int W = 16;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mem_ack, instr_ready, branch_taken;
    logic [W-1:0] mem_data, branch_target;
    logic mem_req, instr_valid;
    logic [W-1:0] mem_addr, instr, instr_pc;

    logic w_reset, w_mem_ack, w_instr_ready, w_branch_taken;
    logic [W-1:0] w_mem_data, w_branch_target;
    logic w_mem_req, w_instr_valid;
    logic [W-1:0] w_mem_addr, w_instr, w_instr_pc;

    fetch_sequencer #(.WORD_SIZE(W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    fetch_sequencer #(.WORD_SIZE(W), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(w_reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ack(w_mem_ack), .mem_data(w_mem_data), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .branch_taken(w_branch_taken), .branch_target(w_branch_target)
    );

    // ctl = {reset, mem_ack, instr_ready, branch_taken}; ob = {mem_req, instr_valid}
    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] data;
        logic [W-1:0] tgt;
        logic [1:0]   ob;
        logic [W-1:0] addr;
        logic [W-1:0] ins;
        logic [W-1:0] ipc;
    } vec_t;
    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic [3:0] ctl, input logic [W-1:0] data, input logic [W-1:0] tgt,
                     input logic [1:0] ob, input logic [W-1:0] addr, input logic [W-1:0] ins,
                     input logic [W-1:0] ipc);
        tbl.push_back('{ctl, data, tgt, ob, addr, ins, ipc});
    endtask

    initial begin
        w_reset = 1'b1; w_mem_ack = 1'b0; w_instr_ready = 1'b0; w_branch_taken = 1'b0;
        w_mem_data = '0; w_branch_target = '0;
        //        rst/ack/rdy/br  data      target    req/vld addr      instr     instr_pc
        v(4'b1000, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000); // reset
        v(4'b1101, 16'hBEEF, 16'h0055, 2'b00, 16'h0000, 16'h0000, 16'h0000); // reset beats ack+branch
        v(4'b0000, 16'h0000, 16'h0000, 2'b10, 16'h0000, 16'h0000, 16'h0000); // first request
        v(4'b0110, 16'h1000, 16'h0000, 2'b01, 16'h0001, 16'h1000, 16'h0000);
        v(4'b0110, 16'hDEAD, 16'h0000, 2'b10, 16'h0001, 16'h1000, 16'h0000); // ack in HOLD ignored
        v(4'b0110, 16'h1001, 16'h0000, 2'b01, 16'h0002, 16'h1001, 16'h0001);
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0002, 16'h1001, 16'h0001);
        v(4'b0100, 16'h1002, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002); // backpressure
        v(4'b0000, 16'h0000, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002);
        v(4'b0100, 16'hDEAD, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002);
        v(4'b0000, 16'h0000, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002);
        v(4'b0000, 16'h0000, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002);
        v(4'b0000, 16'h0000, 16'h0000, 2'b01, 16'h0003, 16'h1002, 16'h0002);
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0003, 16'h1002, 16'h0002); // released
        v(4'b0110, 16'h1003, 16'h0000, 2'b01, 16'h0004, 16'h1003, 16'h0003);
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0004, 16'h1003, 16'h0003);
        v(4'b0011, 16'h0000, 16'h0040, 2'b10, 16'h0004, 16'h1003, 16'h0003); // branch while pending
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0004, 16'h1003, 16'h0003);
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0004, 16'h1003, 16'h0003);
        v(4'b0110, 16'h1004, 16'h0000, 2'b10, 16'h0040, 16'h1003, 16'h0003); // wrong-path dropped
        v(4'b0110, 16'h1040, 16'h0000, 2'b01, 16'h0041, 16'h1040, 16'h0040);
        v(4'b0011, 16'h0000, 16'h0100, 2'b10, 16'h0100, 16'h1040, 16'h0040); // branch in HOLD
        v(4'b0001, 16'h0000, 16'h0200, 2'b10, 16'h0100, 16'h1040, 16'h0040);
        v(4'b0001, 16'h0000, 16'h0300, 2'b10, 16'h0100, 16'h1040, 16'h0040);
        v(4'b0100, 16'hDEAD, 16'h0000, 2'b10, 16'h0300, 16'h1040, 16'h0040); // newest target wins
        v(4'b0110, 16'h1300, 16'h0000, 2'b01, 16'h0301, 16'h1300, 16'h0300);
        v(4'b0010, 16'h0000, 16'h0000, 2'b10, 16'h0301, 16'h1300, 16'h0300);
        v(4'b0101, 16'hDEAD, 16'h0500, 2'b10, 16'h0500, 16'h1300, 16'h0300); // ack+branch in FETCH
        v(4'b0001, 16'h0000, 16'h0600, 2'b10, 16'h0500, 16'h1300, 16'h0300);
        v(4'b0101, 16'hDEAD, 16'h0700, 2'b10, 16'h0700, 16'h1300, 16'h0300); // ack+branch in DISCARD
        v(4'b0001, 16'h0000, 16'h0800, 2'b10, 16'h0700, 16'h1300, 16'h0300);
        v(4'b1100, 16'hDEAD, 16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000); // reset mid-DISCARD
        v(4'b0000, 16'h0000, 16'h0000, 2'b10, 16'h0000, 16'h0000, 16'h0000);
        v(4'b0110, 16'h1000, 16'h0000, 2'b01, 16'h0001, 16'h1000, 16'h0000);
        foreach (tbl[i]) begin
            {reset, mem_ack, instr_ready, branch_taken} = tbl[i].ctl;
            mem_data = tbl[i].data;
            branch_target = tbl[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d mem_req", i), 16'(mem_req), 16'(tbl[i].ob[1]));
            check($sformatf("v%0d instr_valid", i), 16'(instr_valid), 16'(tbl[i].ob[0]));
            check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].addr);
            check($sformatf("v%0d instr", i), instr, tbl[i].ins);
            check($sformatf("v%0d instr_pc", i), instr_pc, tbl[i].ipc);
        end
        // PC wrap from RESET_PC=0xFFFF
        w_reset = 1'b0;
        @(posedge clk); #1;
        check("wrap first req", 16'(w_mem_req), 16'h0001);
        check("wrap first addr", w_mem_addr, 16'hFFFF);
        w_mem_ack = 1'b1; w_mem_data = 16'hABCD;
        @(posedge clk); #1;
        w_mem_ack = 1'b0;
        check("wrap valid", 16'(w_instr_valid), 16'h0001);
        check("wrap instr", w_instr, 16'hABCD);
        check("wrap instr_pc", w_instr_pc, 16'hFFFF);
        w_instr_ready = 1'b1;
        @(posedge clk); #1;
        check("wrap next req", 16'(w_mem_req), 16'h0001);
        check("wrap next addr", w_mem_addr, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
